rr_arbiter_4: RTL
=================

# rr_arbiter_4

Four-requester round-robin arbiter that produces the 2-bit select code consumed by `decoder_2x4`. The arbiter samples a 4-bit request vector and picks one requester fairly. It holds the grant until that requester finishes or a hold timeout expires. `grant_idx` drives the decoder's `A` input, and `grant_valid` qualifies the one-hot decoder output downstream.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles a grant may be held; legal range 2..256.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `req`  in  4  per-requester request; level-sensitive.
- `done`  in  1  current owner's completion strobe; sampled only while granted.
- `grant_idx`  out  2  index of current or most recent owner; feeds `decoder_2x4.A`.
- `grant_valid`  out  1  high while `grant_idx` is an active grant.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- State machine has two states, IDLE and GRANT.
- Internal pointer `last` (2 bit) holds the index of the previous owner.
- Internal counter `hold_cnt` has width clog2(MAX_HOLD).
- **Reset values:** state = IDLE, `last` = 3 (so requester 0 has first priority), `hold_cnt` = 0, `grant_idx` = 0, `grant_valid` = 0, `timeout` = 0.
- **IDLE, `req` = 0:** stay in IDLE.
- **IDLE, `req` ≠ 0:**
  - Scan indices `last`+1, `last`+2, `last`+3, `last` (mod 4, wrap 3→0) and pick the first set bit.
  - Register the pick into `grant_idx`, set `grant_valid` = 1, clear `hold_cnt`, and go to GRANT.
- **GRANT release conditions** (evaluated each cycle, first match wins):
  - `done` = 1: release; no timeout.
  - `req[grant_idx]` = 0: release (requester withdrew); no timeout.
  - `hold_cnt` = MAX_HOLD−1: forced release; `timeout` pulses for 1 cycle.
  - Otherwise: `hold_cnt` += 1 and stay in GRANT.
- **On any release:** `last` ← `grant_idx`, `grant_valid` ← 0, go to IDLE.
- `grant_idx` holds its value while `grant_valid` = 0; it is never forced to 0 except by reset.
- A requester whose request is still asserted after release re-competes at lowest priority.
- **Simultaneous `done` and timeout:** `done` wins; `timeout` stays 0.
- Changes on `req` bits of non-owners during GRANT are ignored.
- **Reset mid-grant:** all outputs drop to reset values immediately (asynchronously); `last` = 3.

## Timing
- Request to grant: `grant_valid` rises on the first rising edge after `req` is seen non-zero in IDLE (1 cycle latency).
- Release to next grant: exactly one IDLE cycle with `grant_valid` = 0 between consecutive grants, so the decoder output is never valid for two owners on adjacent cycles.
- Max grant length is MAX_HOLD cycles of `grant_valid` = 1.
- `timeout` is registered and coincides with the first `grant_valid` = 0 cycle.
- `done` arriving while in IDLE has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `rr_arbiter_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - `NUM_REQ` = 4;
  - `IDX_W` = 2.
- Sub-module `rr_pick4`: combinational; inputs `req[3:0]` and `last[1:0]`; outputs `pick[1:0]` and `any`. It rotates, priority-encodes, then un-rotates.
- The top level contains only the FSM, `hold_cnt`, `last`, and the output registers.
- Integration: `rr_arbiter_4.grant_idx` → `decoder_2x4.A`. The `D` outputs are ANDed with `grant_valid` at the consumer.

## Test plan
- **Reset then single request:** `req` = 4'b0100 → `grant_idx` = 2 with `grant_valid` = 1 one cycle later; `done` pulse → `grant_valid` = 0 next cycle, `last` = 2.
- **Fairness:** hold `req` = 4'b1111 and pulse `done` after 2 cycles of each grant → grant order 0,1,2,3,0 with exactly one invalid cycle between grants.
- **Wrap priority:** after owner 3 releases, `req` = 4'b1001 → next grant is 0, not 3.
- **Timeout:** MAX_HOLD = 4, `req` = 4'b0010 held, no `done` → `grant_valid` high for exactly 4 cycles; `timeout` = 1 for one cycle; then 1 IDLE cycle, then 1 is re-granted if `req[1]` is still high.
- **Withdraw and simultaneous events:**
  - Drop `req[idx]` mid-grant → release with no timeout.
  - `done` on the cycle `hold_cnt` = MAX_HOLD−1 → release with `timeout` = 0.
- **Async reset mid-grant:** assert `rst_n` = 0 between clock edges → `grant_valid`, `grant_idx`, and `timeout` are 0 immediately; after deassert, `req` = 4'b1000 → `grant_idx` = 3.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
package rr_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bundle of the arbiter: request/done in, grant index/qualifier/timeout out.
interface rr_arbiter_4_if;
   import rr_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_valid;
   logic               timeout;

   modport master (
      output req,
      output done,
      input  grant_idx,
      input  grant_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant_idx,
      output grant_valid,
      output timeout
   );

endinterface

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational round-robin pick: rotate so last+1 sits at bit 0, priority-encode, un-rotate.
module rr_pick4
   import rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   pick,
   output logic               any
);

   logic [IDX_W-1:0]   base;
   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;

   assign base = last + IDX_W'(1);

   always_comb begin
      rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req[base + IDX_W'(i)];
      end
   end

   // Descending scan so the lowest rotated position (highest priority) wins.
   always_comb begin
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end
      end
   end

   assign pick = base + off;
   assign any  = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter over four requesters with a bounded hold time per grant.
// Every output is registered; a released grant always leaves one idle cycle before the next.
module rr_arbiter_4
   import rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arbiter_4_if.slave bus
);

   localparam int               CNT_W    = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             to_q, to_d;

   logic [IDX_W-1:0] pick;
   logic             any;
   logic             expired;

   rr_pick4 u_pick (
      .req  (bus.req),
      .last (last_q),
      .pick (pick),
      .any  (any)
   );

   assign expired = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any) begin
               idx_d   = pick;
               vld_d   = 1'b1;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // done beats withdrawal beats expiry, so timeout only fires on a true overrun.
            if (bus.done || !bus.req[idx_q] || expired) begin
               last_d  = idx_q;
               vld_d   = 1'b0;
               state_d = IDLE;
               to_d    = !bus.done && bus.req[idx_q];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= IDX_W'(NUM_REQ - 1);
         idx_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
      end
   end

   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = vld_q;
   assign bus.timeout     = to_q;

endmodule
